// File: rtl/_32bit_logic_checker.sv
// Response checker for 32-bit AND/OR/NOR/XOR units: recomputes the expected result, grades it, and signs it into a MISR.
// Latency: 2 edges from transfer to counters/captures/signature; accepts one vector per cycle while running.
module _32bit_logic_checker #(
    parameter int CNT_W        = 16,
    parameter bit HALT_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      res,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [31:0]      first_fail_exp,
    output logic [31:0]      first_fail_res,
    output logic [31:0]      signature,
    output logic             busy,
    output logic             halted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      POLY    = 32'h04C11DB7;

    state_t            state_q, state_d;
    logic              s1_vld_q, s1_vld_d;
    logic [31:0]       s1_exp_q, s1_exp_d;
    logic [31:0]       s1_res_q, s1_res_d;
    logic [CNT_W-1:0]  s1_idx_q, s1_idx_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
    logic [31:0]       ff_exp_q, ff_exp_d;
    logic [31:0]       ff_res_q, ff_res_d;
    logic [31:0]       sig_q, sig_d;

    logic              xfer;
    logic              mismatch;
    logic [31:0]       exp_val;

    assign xfer     = in_valid && (state_q == S_RUN);
    assign mismatch = s1_vld_q && (s1_exp_q != s1_res_q);

    always_comb begin
        exp_val = 32'h0;
        case (op)
            2'b00:   exp_val = a & b;
            2'b01:   exp_val = a | b;
            2'b10:   exp_val = ~(a | b);
            default: exp_val = a ^ b;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a retiring mismatch takes priority over start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (mismatch && HALT_ON_FAIL) state_d = S_HALTED;
            S_HALTED: if (start) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_RUN);
        halted   = (state_q == S_HALTED);
        busy     = (state_q == S_RUN) || s1_vld_q;
    end

    always_comb begin
        s1_vld_d = xfer;
        s1_exp_d = s1_exp_q;
        s1_res_d = s1_res_q;
        s1_idx_d = s1_idx_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        ff_idx_d = ff_idx_q;
        ff_exp_d = ff_exp_q;
        ff_res_d = ff_res_q;
        sig_d    = sig_q;

        if (xfer) begin
            s1_exp_d = exp_val;
            s1_res_d = res;
            s1_idx_d = idx_q;
            if (idx_q != CNT_MAX) idx_d = idx_q + CNT_ONE;
        end

        if (s1_vld_q) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ s1_res_q;
            if (!mismatch) begin
                if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
            end else begin
                if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
                err_d = 1'b1;
                // err_q still low means nothing has failed since reset/clear
                if (!err_q) begin
                    ff_idx_d = s1_idx_q;
                    ff_exp_d = s1_exp_q;
                    ff_res_d = s1_res_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            s1_vld_q <= 1'b0;
            s1_exp_q <= 32'h0;
            s1_res_q <= 32'h0;
            s1_idx_q <= '0;
            idx_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            err_q    <= 1'b0;
            ff_idx_q <= '0;
            ff_exp_q <= 32'h0;
            ff_res_q <= 32'h0;
            sig_q    <= 32'h0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_exp_q <= s1_exp_d;
            s1_res_q <= s1_res_d;
            s1_idx_q <= s1_idx_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            ff_idx_q <= ff_idx_d;
            ff_exp_q <= ff_exp_d;
            ff_res_q <= ff_res_d;
            sig_q    <= sig_d;
        end
    end

    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign err            = err_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_res = ff_res_q;
    assign signature      = sig_q;

endmodule

// File: tb/tb__32bit_logic_checker.sv
// Bench for _32bit_logic_checker: scoreboard of in-flight vectors plus a reference model, and a narrow-counter instance.
module tb__32bit_logic_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: CNT_W=16, HALT_ON_FAIL=1
    logic        rst_n = 1'b0, clear = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0, b = 32'h0, res = 32'h0;
    logic        in_ready, err, busy, halted;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [31:0] first_fail_exp, first_fail_res, signature;

    // Saturation instance: CNT_W=2, HALT_ON_FAIL=0
    logic        clear2 = 1'b0, start2 = 1'b0, in_valid2 = 1'b0;
    logic [1:0]  op2 = 2'b00;
    logic [31:0] a2 = 32'h0, b2 = 32'h0, res2 = 32'h0;
    logic        in_ready2, err2, busy2, halted2;
    logic [1:0]  pass_cnt2, fail_cnt2, first_fail_idx2;
    logic [31:0] first_fail_exp2, first_fail_res2, signature2;

    _32bit_logic_checker #(.CNT_W(16), .HALT_ON_FAIL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .res(res),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
        .first_fail_res(first_fail_res), .signature(signature),
        .busy(busy), .halted(halted)
    );

    _32bit_logic_checker #(.CNT_W(2), .HALT_ON_FAIL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .start(start2), .op(op2),
        .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2), .res(res2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err(err2),
        .first_fail_idx(first_fail_idx2), .first_fail_exp(first_fail_exp2),
        .first_fail_res(first_fail_res2), .signature(signature2),
        .busy(busy2), .halted(halted2)
    );

    typedef struct {
        logic [31:0] exp;
        logic [31:0] res;
        logic [15:0] idx;
    } vec_t;

    vec_t sb_q[$];

    int          m_state = 0;  // 0 IDLE, 1 RUN, 2 HALTED
    logic [15:0] m_pass = 0, m_fail = 0, m_idx = 0, m_ffi = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_ffe = 0, m_ffr = 0, m_sig = 0;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] ref_f(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return ~(x | y);
            default: return x ^ y;
        endcase
    endfunction

    // One clock edge: push a transfer onto the scoreboard, pop a retire into the model
    task automatic tick();
        logic xfer, retiring, fail_now;
        int   st0;
        vec_t nv, e;
        xfer     = in_valid && (m_state == 1);
        retiring = (sb_q.size() != 0);
        st0      = m_state;
        nv.exp   = ref_f(op, a, b);
        nv.res   = res;
        nv.idx   = m_idx;
        fail_now = 1'b0;
        @(posedge clk);
        #1;
        if (!rst_n || clear) begin
            m_state = 0; m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 0;
            m_err = 1'b0; m_ffe = 0; m_ffr = 0; m_sig = 0;
            sb_q.delete();
        end else begin
            if (retiring) begin
                e = sb_q.pop_front();
                m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? 32'h04C11DB7 : 32'h0) ^ e.res;
                if (e.exp === e.res) begin
                    if (m_pass != 16'hFFFF) m_pass = m_pass + 16'd1;
                end else begin
                    fail_now = 1'b1;
                    if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
                    if (!m_err) begin
                        m_ffi = e.idx; m_ffe = e.exp; m_ffr = e.res;
                    end
                    m_err = 1'b1;
                end
            end
            if (st0 == 1 && fail_now) m_state = 2;
            else if (st0 != 1 && start) m_state = 1;
            if (xfer) begin
                sb_q.push_back(nv);
                if (m_idx != 16'hFFFF) m_idx = m_idx + 16'd1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b halted=%b err=%b want 0/0/0", busy, halted, err); end
        checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts got pass=%0d fail=%0d want 0/0", pass_cnt, fail_cnt); end
        checks++; if (signature !== 32'h0 || first_fail_idx !== 16'd0 || first_fail_exp !== 32'h0 || first_fail_res !== 32'h0) begin errors++; $display("FAIL reset_regs got sig=%h ffi=%0d ffe=%h ffr=%h want zeros", signature, first_fail_idx, first_fail_exp, first_fail_res); end
        checks++; if (pass_cnt2 !== 2'd0 || in_ready2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got pass=%0d rdy=%b want 0/0", pass_cnt2, in_ready2); end
    endtask

    task automatic test_nor_stream();
        logic [31:0] va[4], vb[4], vr[4];
        va = '{32'hFFFFFFFF, 32'h05453FAF, 32'h00000000, 32'h00000000};
        vb = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        vr = '{32'h00000000, 32'hFABAC050, 32'hFFFFFFFE, 32'h00000000};
        op = 2'b10;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_ready got rdy=%b busy=%b want 1/1", in_ready, busy); end
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; res = vr[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (pass_cnt !== 16'd3) begin errors++; $display("FAIL nor_latency got pass=%0d want 3", pass_cnt); end
        tick();
        checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL nor_counts got pass=%0d fail=%0d err=%b want 4/0/0", pass_cnt, fail_cnt, err); end
        checks++; if (signature !== m_sig) begin errors++; $display("FAIL nor_signature got=%h want=%h", signature, m_sig); end
    endtask

    task automatic test_wrong_function();
        clear = 1'b1; tick(); clear = 1'b0;
        op = 2'b10;
        start = 1'b1; tick(); start = 1'b0;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; res = 32'hFFFFFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (fail_cnt !== 16'd1 || err !== 1'b1 || pass_cnt !== 16'd0) begin errors++; $display("FAIL wrongfn_counts got fail=%0d err=%b pass=%0d want 1/1/0", fail_cnt, err, pass_cnt); end
        checks++; if (first_fail_idx !== 16'd0 || first_fail_exp !== 32'h00000000 || first_fail_res !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrongfn_capture got idx=%0d exp=%h res=%h want 0/00000000/ffffffff", first_fail_idx, first_fail_exp, first_fail_res); end
        checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL wrongfn_halt got halted=%b rdy=%b want 1/0", halted, in_ready); end
    endtask

    task automatic test_inflight_halt();
        clear = 1'b1; tick(); clear = 1'b0;
        op = 2'b00;
        start = 1'b1; tick(); start = 1'b0;
        a = 32'hF0F0F0F0; b = 32'hFF00FF00; res = 32'h12345678; in_valid = 1'b1;
        tick();
        a = 32'hAAAA5555; b = 32'h0F0F0F0F; res = 32'h0A0A0505;
        tick();
        a = 32'h1; b = 32'h1; res = 32'h1;
        tick();
        checks++; if (halted !== 1'b1 || fail_cnt !== 16'd1 || pass_cnt !== 16'd1) begin errors++; $display("FAIL inflight_counts got halted=%b fail=%0d pass=%0d want 1/1/1", halted, fail_cnt, pass_cnt); end
        tick();
        checks++; if (pass_cnt !== 16'd1 || busy !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL inflight_reject got pass=%0d busy=%b want 1/0", pass_cnt, busy); end
        checks++; if (first_fail_exp !== 32'hF000F000 || first_fail_res !== 32'h12345678) begin errors++; $display("FAIL inflight_capture got exp=%h res=%h want f000f000/12345678", first_fail_exp, first_fail_res); end
        in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (in_ready !== 1'b1 || halted !== 1'b0 || pass_cnt !== 16'd1 || fail_cnt !== 16'd1 || err !== 1'b1) begin errors++; $display("FAIL resume got rdy=%b halted=%b pass=%0d fail=%0d err=%b want 1/0/1/1/1", in_ready, halted, pass_cnt, fail_cnt, err); end
        op = 2'b11; a = 32'hDEADBEEF; b = 32'h0000FFFF; res = 32'hDEAD4110; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (pass_cnt !== m_pass || pass_cnt !== 16'd2 || first_fail_idx !== 16'd0) begin errors++; $display("FAIL resume_vector got pass=%0d ffi=%0d want 2/0", pass_cnt, first_fail_idx); end
        checks++; if (signature !== m_sig) begin errors++; $display("FAIL inflight_signature got=%h want=%h", signature, m_sig); end
    endtask

    task automatic test_signature();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        op = 2'b01;
        start = 1'b1; tick(); start = 1'b0;
        a = 32'h0; b = 32'h1; res = 32'h00000001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (signature !== 32'h00000001) begin errors++; $display("FAIL sig_first got=%h want=00000001", signature); end
        a = 32'h0; b = 32'h0; res = 32'h00000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (signature !== 32'h00000002 || pass_cnt !== 16'd2) begin errors++; $display("FAIL sig_second got sig=%h pass=%0d want 00000002/2", signature, pass_cnt); end
        // Drive the top bit through so the polynomial feedback is exercised
        for (int i = 0; i < 31; i++) begin
            res = 32'h0; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0; tick();
        checks++; if (signature !== m_sig) begin errors++; $display("FAIL sig_feedback got=%h want=%h", signature, m_sig); end
    endtask

    task automatic test_midrun_reset();
        op = 2'b00; a = 32'hFFFF0000; b = 32'h00FFFF00; res = 32'h00FF0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || signature !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL midreset_regs got pass=%0d fail=%0d sig=%h err=%b want zeros", pass_cnt, fail_cnt, signature, err); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midreset_flags got rdy=%b busy=%b halted=%b want 0/0/0", in_ready, busy, halted); end
        tick();
        checks++; if (pass_cnt !== 16'd0 || signature !== 32'h0) begin errors++; $display("FAIL midreset_discard got pass=%0d sig=%h want 0/0", pass_cnt, signature); end
    endtask

    task automatic test_saturation();
        op2 = 2'b11;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a2 = 32'h11111111 * (i + 1); b2 = 32'h0F0F0F0F; res2 = (32'h11111111 * (i + 1)) ^ 32'h0F0F0F0F;
            in_valid2 = 1'b1; tick();
        end
        in_valid2 = 1'b0; tick();
        checks++; if (pass_cnt2 !== 2'd3 || fail_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_pass got pass=%0d fail=%0d want 3/0", pass_cnt2, fail_cnt2); end
        a2 = 32'h0; b2 = 32'h0; res2 = 32'h1; in_valid2 = 1'b1; tick();
        in_valid2 = 1'b0; tick();
        checks++; if (fail_cnt2 !== 2'd1 || halted2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++; $display("FAIL nohalt got fail=%0d halted=%b rdy=%b want 1/0/1", fail_cnt2, halted2, in_ready2); end
        clear2 = 1'b1; start2 = 1'b1; tick(); clear2 = 1'b0; start2 = 1'b0;
        checks++; if (pass_cnt2 !== 2'd0 || in_ready2 !== 1'b0 || busy2 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL clear_start got pass=%0d rdy=%b busy=%b err=%b want 0/0/0/0", pass_cnt2, in_ready2, busy2, err2); end
    endtask

    initial begin
        test_reset();
        test_nor_stream();
        test_wrong_function();
        test_inflight_halt();
        test_signature();
        test_midrun_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
